sincos_cordic: RTL and testbench
================================

# sincos_cordic

- Iterative IEEE-754 single-precision sine/cosine unit that returns sin(x) and cos(x) together from one start/done transaction.
- Unpacks the float operand to Q2.30 fixed point and folds it into [0, π/2].
- Runs a parametrised number of CORDIC rotation iterations, then repacks both results to float.
- Sits beside the fp add/mul units in the datapath as the transcendental operator.

## Interface
- ITER, 24, CORDIC iterations, legal range 8..30
- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- sine_start  in  1  one-cycle request; sampled only in IDLE
- opx  in  [0:31]  operand; bit 0 sign, bits 1:8 exponent, bits 9:31 fraction
- sine_result  out  [0:31]  sin(opx)
- cos_result  out  [0:31]  cos(opx)
- sine_done  out  1  one-cycle pulse; results valid from this cycle on
- busy  out  1  high from the cycle after start is accepted through the done cycle
- err  out  1  domain error flag, updated together with sine_done

## Operation
- Reset values: sine_result=0, cos_result=0, sine_done=0, busy=0, err=0, FSM=IDLE.
- FSM: IDLE -> UNPACK -> ROT (ITER cycles, counter 0..ITER-1) -> PACK -> DONE -> IDLE.
- UNPACK:
  - Classify the operand:
    - NaN/Inf (exp=255) -> NAN class.
    - |x| > π (magnitude bits > 0x40490FDB) -> NAN class with err.
    - exp < 97, including zero and denormals -> TINY class.
    - Otherwise NORMAL.
  - NORMAL: z = {1,frac} shifted by (exp-120), right shifts truncating, giving unsigned Q2.30.
  - If z > π/2 (0x6487ED51): z = π - z and set cneg.
  - Rotation starts from x=K, y=0, z, with K = 0x26DD3B6A.
- ROT, iteration i:
  - d = sign(z).
  - x' = x - d·(y>>>i), y' = y + d·(x>>>i), z' = z - d·atan(2^-i).
  - All values are 32-bit signed Q2.30 with arithmetic shifts.
- PACK, per result:
  - Take the absolute value.
  - Find the leading one, normalise, and truncate to 23 fraction bits.
  - Exponent = 127 + (position of the leading one) - 30.
  - A zero magnitude packs to 0.
  - sin sign = opx sign; cos sign = cneg.
  - Class overrides:
    - TINY: sin = opx unchanged, cos = 0x3F800000.
    - NAN: both results 0x7FC00000.
    - err = 1 only for the out-of-domain case; NaN/Inf inputs give err = 0.
- Special classes still traverse every state, so latency is uniform.
- Results and err hold until the next PACK; they are not cleared in IDLE.

## Timing
- Start accepted on edge T0, i.e. sine_start high in IDLE.
- busy is high from T0+1; sine_done pulses high for cycle T0+ITER+3, with results stable.
- busy falls after the done cycle, and a new start may be sampled in the cycle after done.
- sine_start while busy or in DONE is ignored, not queued.
- opx is sampled only at the T0 edge; later changes have no effect.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs at reset values; no done pulse follows.
- Accuracy for ITER ≥ 22: |result - true| ≤ 2^-20 absolute.

## Configuration
- SINCOS_ROUND_EN:
  - Defined: PACK rounds to nearest-even on the discarded bits. A mantissa carry-out increments the exponent.
  - Undefined: PACK truncates.
- Latency is identical either way.

## Structure
- sincos_pkg holds:
  - ITER_MAX=30.
  - The atan(2^-i) Q2.30 table, 30 entries.
  - K_Q230=0x26DD3B6A, PI_Q230=0xC90FDAA2 (unsigned), HALF_PI_Q230=0x6487ED51.
  - FP constants: FP_ONE=0x3F800000, FP_QNAN=0x7FC00000, FP_PI=0x40490FDB.
  - State enum.
- Sub-module sincos_fx2fp: combinational Q2.30 magnitude + sign -> float pack, with optional rounding. It is instantiated twice, once for sin and once for cos.

## Test plan
- Reset with n_rst=0, then release -> all outputs 0; start with opx=0x00000000 -> done at T0+27 (ITER=24), sine_result=0x00000000, cos_result=0x3F800000, err=0.
- opx=0x3F000000 (0.5) -> sine_result ≈ 0x3EF57744 and cos_result ≈ 0x3F60A940, each within 2^-20 absolute; err=0.
- opx=0xBFC90FDB (-π/2) -> sine_result ≈ 0xBF800000, |cos_result| ≤ 2^-20; opx=0x40490FDB (π) -> |sin| ≤ 2^-20 and cos ≈ 0xBF800000 (fold path).
- opx=0x7FC00000 -> both results 0x7FC00000, err=0; opx=0x40490FDC -> both results 0x7FC00000, err=1; done timing unchanged.
- Second start pulse at T0+5 with a different opx -> ignored, results reflect the first operand, exactly one done pulse.
- Reset asserted at T0+10 -> busy=0, done never pulses, results 0; a fresh start after release completes normally.

Source files
------------

// File: rtl/sincos_pkg.sv
// sincos_pkg: shared constants, CORDIC arctangent table and FSM/class types for sincos_cordic.
package sincos_pkg;

   localparam int ITER_MAX = 30;

   localparam logic [31:0] K_Q230       = 32'h26DD3B6A;
   localparam logic [31:0] PI_Q230      = 32'hC90FDAA2;
   localparam logic [31:0] HALF_PI_Q230 = 32'h6487ED51;

   localparam logic [31:0] FP_ONE  = 32'h3F800000;
   localparam logic [31:0] FP_QNAN = 32'h7FC00000;
   localparam logic [31:0] FP_PI   = 32'h40490FDB;

   // atan(2^-i) in Q2.30, i = 0 .. ITER_MAX-1
   localparam logic [31:0] ATAN_TABLE [ITER_MAX] = '{
      32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6, 32'h03FEAB76,
      32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55, 32'h003FFFEA, 32'h001FFFFD,
      32'h000FFFFF, 32'h0007FFFF, 32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF,
      32'h00007FFF, 32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
      32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F, 32'h0000003F,
      32'h0000001F, 32'h0000000F, 32'h00000007, 32'h00000003, 32'h00000001
   };

   typedef enum logic [2:0] {ST_IDLE, ST_UNPACK, ST_ROT, ST_PACK, ST_DONE} state_t;
   typedef enum logic [1:0] {CLS_NORMAL, CLS_TINY, CLS_NAN} cls_t;

endpackage

// File: rtl/sincos_fx2fp.sv
// sincos_fx2fp: packs an unsigned Q2.30 magnitude plus sign into an IEEE-754 single.
// Define SINCOS_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module sincos_fx2fp (
   input  logic [31:0] mag,
   input  logic        sign,
   output logic [31:0] fp
);
   logic [4:0]  lead;
   logic [31:0] norm;
   logic [7:0]  exp_b;
   logic [22:0] frac;

   always_comb begin
      lead = '0;
      for (int i = 0; i < 32; i++)
         if (mag[i]) lead = 5'(i);
   end

   assign norm = mag << (5'd31 - lead);

   // Bit p of a Q2.30 value weighs 2^(p-30), so the biased exponent is 97 + p
`ifdef SINCOS_ROUND_EN
   logic        round_up;
   logic [23:0] frac_inc;
   logic        unused_norm;
   assign round_up    = norm[7] & (norm[8] | (|norm[6:0]));
   assign frac_inc    = {1'b0, norm[30:8]} + {23'd0, round_up};
   assign frac        = frac_inc[22:0];
   assign exp_b       = 8'd97 + {3'd0, lead} + {7'd0, frac_inc[23]};
   assign unused_norm = norm[31];
`else
   logic unused_norm;
   assign frac        = norm[30:8];
   assign exp_b       = 8'd97 + {3'd0, lead};
   assign unused_norm = ^{norm[31], norm[7:0]};
`endif

   assign fp = (mag == 32'd0) ? 32'd0 : {sign, exp_b, frac};

endmodule

// File: rtl/sincos_cordic.sv
// sincos_cordic: iterative float sin/cos using CORDIC rotation in Q2.30 fixed point.
// Optional SINCOS_ROUND_EN makes the result packers round to nearest-even instead of truncating.
module sincos_cordic
   import sincos_pkg::*;
#(
   parameter int ITER = 24
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        sine_start,
   input  logic [0:31] opx,
   output logic [0:31] sine_result,
   output logic [0:31] cos_result,
   output logic        sine_done,
   output logic        busy,
   output logic        err
);
   localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

   state_t             state_reg, state_next;
   logic [4:0]         cnt_reg;
   logic [31:0]        opx_reg;
   cls_t               cls_reg;
   logic               dom_err_reg, cneg_reg, err_reg;
   logic signed [31:0] x_reg, y_reg, z_reg;
   logic [31:0]        sin_reg, cos_reg;

   logic [7:0]         op_exp;
   logic [31:0]        op_mant, z_unfold, z_fold;
   cls_t               op_cls;
   logic               op_dom_err, op_cneg;

   assign op_exp  = opx_reg[30:23];
   assign op_mant = {8'd0, 1'b1, opx_reg[22:0]};

   always_comb begin
      op_cls     = CLS_NORMAL;
      op_dom_err = 1'b0;
      if (op_exp == 8'hFF) begin
         op_cls = CLS_NAN;
      end else if (opx_reg[30:0] > FP_PI[30:0]) begin
         op_cls     = CLS_NAN;
         op_dom_err = 1'b1;
      end else if (op_exp < 8'd97) begin
         op_cls = CLS_TINY;
      end
      if (op_exp >= 8'd120) z_unfold = op_mant << (op_exp - 8'd120);
      else                  z_unfold = op_mant >> (8'd120 - op_exp);
      // fold (pi/2, pi] onto [0, pi/2): sin unchanged, cos negated
      op_cneg = (z_unfold > HALF_PI_Q230);
      z_fold  = op_cneg ? (PI_Q230 - z_unfold) : z_unfold;
   end

   logic signed [31:0] x_shr, y_shr, atan_i;
   logic [31:0]        sin_mag, cos_mag, sin_fp, cos_fp;

   assign x_shr   = x_reg >>> cnt_reg;
   assign y_shr   = y_reg >>> cnt_reg;
   assign atan_i  = signed'(ATAN_TABLE[cnt_reg]);
   assign sin_mag = y_reg[31] ? -y_reg : y_reg;
   assign cos_mag = x_reg[31] ? -x_reg : x_reg;

   sincos_fx2fp u_sin_pack (.mag(sin_mag), .sign(opx_reg[31]), .fp(sin_fp));
   sincos_fx2fp u_cos_pack (.mag(cos_mag), .sign(cneg_reg),    .fp(cos_fp));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != ST_IDLE);
      sine_done  = (state_reg == ST_DONE);
      case (state_reg)
         ST_IDLE:   if (sine_start) state_next = ST_UNPACK;
         ST_UNPACK: state_next = ST_ROT;
         ST_ROT:    if (cnt_reg == LAST_ITER) state_next = ST_PACK;
         ST_PACK:   state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_reg     <= '0;
         opx_reg     <= '0;
         cls_reg     <= CLS_NORMAL;
         dom_err_reg <= 1'b0;
         cneg_reg    <= 1'b0;
         err_reg     <= 1'b0;
         x_reg       <= '0;
         y_reg       <= '0;
         z_reg       <= '0;
         sin_reg     <= '0;
         cos_reg     <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: if (sine_start) opx_reg <= opx;
            ST_UNPACK: begin
               cls_reg     <= op_cls;
               dom_err_reg <= op_dom_err;
               cneg_reg    <= op_cneg;
               x_reg       <= signed'(K_Q230);
               y_reg       <= '0;
               z_reg       <= signed'(z_fold);
               cnt_reg     <= '0;
            end
            ST_ROT: begin
               if (!z_reg[31]) begin
                  x_reg <= x_reg - y_shr;
                  y_reg <= y_reg + x_shr;
                  z_reg <= z_reg - atan_i;
               end else begin
                  x_reg <= x_reg + y_shr;
                  y_reg <= y_reg - x_shr;
                  z_reg <= z_reg + atan_i;
               end
               cnt_reg <= cnt_reg + 5'd1;
            end
            ST_PACK: begin
               err_reg <= dom_err_reg;
               case (cls_reg)
                  CLS_TINY: begin
                     sin_reg <= opx_reg;
                     cos_reg <= FP_ONE;
                  end
                  CLS_NAN: begin
                     sin_reg <= FP_QNAN;
                     cos_reg <= FP_QNAN;
                  end
                  default: begin
                     sin_reg <= sin_fp;
                     cos_reg <= cos_fp;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   assign sine_result = sin_reg;
   assign cos_result  = cos_reg;
   assign err         = err_reg;

endmodule

// File: tb/tb_sincos_cordic.sv
// tb_sincos_cordic: directed vector table plus hand-written start/reset corner sequences.
module tb_sincos_cordic;
   localparam int  ITER = 24;
   localparam int  NV   = 15;
   localparam real TOL  = 1.0 / 1048576.0;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        sine_start;
   logic [0:31] opx;
   logic [0:31] sine_result, cos_result;
   logic        sine_done, busy, err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sincos_cordic #(.ITER(ITER)) dut (
      .clk(clk), .n_rst(n_rst), .sine_start(sine_start), .opx(opx),
      .sine_result(sine_result), .cos_result(cos_result),
      .sine_done(sine_done), .busy(busy), .err(err)
   );

   typedef struct packed {
      logic [31:0] opx;
      logic        exact;
      logic [31:0] sin_bits;
      logic [31:0] cos_bits;
      logic        err;
   } vec_t;

   vec_t vecs [NV];
   real  sin_val [NV];
   real  cos_val [NV];

   function automatic real fp2real(input logic [31:0] f);
      real m;
      int  e;
      e = int'(f[30:23]);
      if (e == 0) return 0.0;
      m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      return f[31] ? -m : m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_near(input string name, input logic [31:0] act, input real exp);
      real a;
      a = fp2real(act);
      n_cmp++;
      if ((a - exp > TOL) || (exp - a > TOL)) begin
         n_bad++;
         $display("FAIL %s: got %08h (%.9f), expected %.9f within 2^-20", name, act, a, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] v);
      @(negedge clk);
      opx        = v;
      sine_start = 1'b1;
      @(posedge clk); #1;
      sine_start = 1'b0;
      opx        = ~v;
   endtask

   // returns the cycle offset from the accepting edge (T0+1 == 1), or -1 on timeout
   task automatic wait_done(output int lat);
      int k;
      k   = 1;
      lat = -1;
      while (lat < 0 && k <= ITER + 40) begin
         if (sine_done) lat = k;
         else begin
            @(posedge clk); #1;
            k++;
         end
      end
   endtask

   task automatic run_vec(input int i);
      int lat;
      start_op(vecs[i].opx);
      chk("busy_at_t0p1", 32'(busy), 32'd1);
      wait_done(lat);
      chk("done_latency", 32'(lat), 32'(ITER + 3));
      if (vecs[i].exact) begin
         chk("sin_bits", sine_result, vecs[i].sin_bits);
         chk("cos_bits", cos_result, vecs[i].cos_bits);
      end else begin
         chk_near("sin_val", sine_result, sin_val[i]);
         chk_near("cos_val", cos_result, cos_val[i]);
      end
      chk("err", 32'(err), 32'(vecs[i].err));
      $display("op %08h -> sin %08h cos %08h err %0b latency %0d",
               vecs[i].opx, sine_result, cos_result, err, lat);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(sine_done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int ndone;
      int lat;

      vecs[0]  = '{32'h00000000, 1'b1, 32'h00000000, 32'h3F800000, 1'b0};
      vecs[1]  = '{32'h3F000000, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[2]  = '{32'hBFC90FDB, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[3]  = '{32'h40490FDB, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[4]  = '{32'h7FC00000, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0};
      vecs[5]  = '{32'h40490FDC, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b1};
      vecs[6]  = '{32'hFF800000, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0};
      vecs[7]  = '{32'h30000000, 1'b1, 32'h30000000, 32'h3F800000, 1'b0};
      vecs[8]  = '{32'h80000000, 1'b1, 32'h80000000, 32'h3F800000, 1'b0};
      vecs[9]  = '{32'hBF800000, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[10] = '{32'h3FC00000, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[11] = '{32'h40000000, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[12] = '{32'h40400000, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[13] = '{32'h30800000, 1'b0, 32'h0, 32'h0, 1'b0};
      vecs[14] = '{32'hC0490FDB, 1'b0, 32'h0, 32'h0, 1'b0};
      for (int i = 0; i < NV; i++) begin
         sin_val[i] = 0.0;
         cos_val[i] = 0.0;
      end
      sin_val[1]  =  0.4794255386;  cos_val[1]  =  0.8775825619;
      sin_val[2]  = -1.0;           cos_val[2]  =  0.0;
      sin_val[3]  =  0.0;           cos_val[3]  = -1.0;
      sin_val[9]  = -0.8414709848;  cos_val[9]  =  0.5403023059;
      sin_val[10] =  0.9974949866;  cos_val[10] =  0.0707372017;
      sin_val[11] =  0.9092974268;  cos_val[11] = -0.4161468365;
      sin_val[12] =  0.1411200081;  cos_val[12] = -0.9899924966;
      sin_val[13] =  0.0;           cos_val[13] =  1.0;
      sin_val[14] =  0.0;           cos_val[14] = -1.0;

      n_rst      = 1'b0;
      sine_start = 1'b0;
      opx        = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_sin", sine_result, 32'h0);
      chk("rst_cos", cos_result, 32'h0);
      chk("rst_done", 32'(sine_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      for (int i = 0; i < NV; i++) run_vec(i);

      // second start mid-run and a start during DONE must both be dropped
      start_op(32'h7FC00000);
      ndone = 0;
      lat   = -1;
      for (int k = 1; k < ITER + 12; k++) begin
         if (sine_done) begin
            ndone++;
            if (lat < 0) lat = k;
         end
         @(negedge clk);
         sine_start = (k == 5) || (k == ITER + 3);
         opx        = 32'h00000000;
         @(posedge clk); #1;
      end
      sine_start = 1'b0;
      chk("ignored_start_done_count", 32'(ndone), 32'd1);
      chk("ignored_start_latency", 32'(lat), 32'(ITER + 3));
      chk("ignored_start_sin", sine_result, 32'h7FC00000);
      chk("ignored_start_cos", cos_result, 32'h7FC00000);
      chk("ignored_start_idle", 32'(busy), 32'd0);
      $display("op 7fc00000 with extra starts -> sin %08h cos %08h done pulses %0d",
               sine_result, cos_result, ndone);

      // asynchronous reset in the middle of a rotation
      start_op(32'h3F000000);
      repeat (9) begin
         @(posedge clk); #1;
      end
      n_rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(sine_done), 32'd0);
      chk("midrst_sin", sine_result, 32'h0);
      chk("midrst_cos", cos_result, 32'h0);
      chk("midrst_err", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      ndone = 0;
      for (int k = 0; k < ITER + 8; k++) begin
         @(posedge clk); #1;
         if (sine_done) ndone++;
      end
      chk("midrst_no_done", 32'(ndone), 32'd0);
      $display("reset at T0+10 -> busy %0b done pulses %0d", busy, ndone);
      run_vec(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
